// File: rtl/interrupt_controller_if.sv
// Processor/peripheral side signals of the interrupt controller: register bus
// address/strobe, per-source raise/ack lines and the CPU request handshake.
interface interrupt_controller_if #(
  parameter int unsigned NumSources = 2
);
  logic [7:0]            bus_addr;
  logic                  bus_we;
  logic [NumSources-1:0] raise;
  logic [NumSources-1:0] ack;
  logic                  cpu_req;
  logic [2:0]            cpu_id;
  logic                  cpu_ack;

  modport master (
    output bus_addr, bus_we, raise, cpu_ack,
    input  ack, cpu_req, cpu_id
  );

  modport slave (
    input  bus_addr, bus_we, raise, cpu_ack,
    output ack, cpu_req, cpu_id
  );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: arbitrates level-raised sources (lowest
// index wins), holds one request to the CPU and pulses an ack back to the source.
module interrupt_controller #(
  parameter int unsigned NumSources  = 2,
  parameter logic [7:0]  IntCtrlBase = 8'hE0,
  parameter logic [7:0]  InitialMask = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  wire  [7:0]            io_bus_data,
  interrupt_controller_if.slave bus
);

  localparam int unsigned N        = NumSources;
  localparam logic [7:0]  AddrPend = IntCtrlBase;
  localparam logic [7:0]  AddrMask = 8'(IntCtrlBase + 8'd1);

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

  state_t       r_state;
  logic [N-1:0] r_mask;
  logic [N-1:0] r_ack;
  logic         r_req;
  logic [2:0]   r_id;
  logic         r_rd_oe;
  logic [7:0]   r_rd_data;

  logic [N-1:0] w_elig;
  logic [2:0]   w_sel_id;
  logic [N-1:0] w_id_onehot;
  logic [N-1:0] w_wr_data;

  assign w_elig      = bus.raise & r_mask;
  assign w_id_onehot = N'(1) << r_id;
  assign w_wr_data   = N'(io_bus_data);

  // Lowest eligible index wins.
  always_comb begin
    w_sel_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel_id = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_id    <= '0;
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_id    <= w_sel_id;
          end
        end
        REQ: begin
          if (bus.cpu_ack) begin
            r_state <= ACK;
            r_req   <= 1'b0;
            r_ack   <= w_id_onehot;
          end
        end
        ACK:     r_state <= HOLD;
        // One dead cycle lets the serviced source clear its raise line.
        HOLD:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Mask register and registered read-back select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= InitialMask[N-1:0];
      r_rd_oe   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (bus.bus_we && (bus.bus_addr == AddrMask)) r_mask <= w_wr_data;
      r_rd_oe   <= 1'b0;
      r_rd_data <= '0;
      if (!bus.bus_we && (bus.bus_addr == AddrPend)) begin
        r_rd_oe   <= 1'b1;
        r_rd_data <= 8'(bus.raise);
      end else if (!bus.bus_we && (bus.bus_addr == AddrMask)) begin
        r_rd_oe   <= 1'b1;
        r_rd_data <= 8'(r_mask);
      end
    end
  end

  assign io_bus_data = r_rd_oe ? r_rd_data : 8'hzz;
  assign bus.ack     = r_ack;
  assign bus.cpu_req = r_req;
  assign bus.cpu_id  = r_id;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomized checks of interrupt_controller against a simple
// priority/service-order model.
module tb_interrupt_controller;

  localparam int unsigned N      = 2;
  localparam logic [7:0]  PEND_A = 8'hE0;
  localparam logic [7:0]  MASK_A = 8'hE1;
  localparam logic [7:0]  IDLE_A = 8'h10;
  localparam logic [7:0]  PROBE  = 8'hA4;

  logic       clk = 1'b0;
  logic       rst_n;
  wire  [7:0] bus_data;
  logic       tb_oe;
  logic [7:0] tb_dout;
  int         n_checks = 0;
  int         n_errors = 0;

  interrupt_controller_if #(.NumSources(N)) bus_if ();

  interrupt_controller #(
    .NumSources (N),
    .IntCtrlBase(8'hE0),
    .InitialMask(8'hFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_bus_data(bus_data),
    .bus        (bus_if)
  );

  assign bus_data = tb_oe ? tb_dout : 8'hzz;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [2:0] id,
                            input logic [N-1:0] ack);
    chk({tag, ".req"}, 32'(bus_if.cpu_req), 32'(req));
    chk({tag, ".ack"}, 32'(bus_if.ack), 32'(ack));
    if (req) chk({tag, ".id"}, 32'(bus_if.cpu_id), 32'(id));
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_if.bus_addr = a;
    bus_if.bus_we   = 1'b1;
    tb_oe           = 1'b1;
    tb_dout         = d;
    tick();
    bus_if.bus_we   = 1'b0;
    tb_oe           = 1'b0;
    bus_if.bus_addr = IDLE_A;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_if.bus_addr = a;
    bus_if.bus_we   = 1'b0;
    tick();
    d = bus_data;
    bus_if.bus_addr = IDLE_A;
    tick();
  endtask

  // A released bus reads back exactly what the bench drives onto it.
  task automatic check_release(input string tag);
    tb_oe   = 1'b1;
    tb_dout = PROBE;
    #1;
    chk(tag, 32'(bus_data), 32'(PROBE));
    tb_oe   = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int m, r, e, low, id, dly;

    rst_n          = 1'b0;
    tb_oe          = 1'b0;
    tb_dout        = 8'h00;
    bus_if.bus_addr = IDLE_A;
    bus_if.bus_we  = 1'b0;
    bus_if.raise   = '0;
    bus_if.cpu_ack = 1'b0;

    tick();
    tick();
    expect_out("reset", 1'b0, 3'd0, 2'b00);
    chk("reset.id", 32'(bus_if.cpu_id), 32'd0);
    check_release("reset.bus");
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(MASK_A, d);
    chk("reset.mask", 32'(d), 32'h03);

    // Single source
    bus_if.raise = 2'b01;
    tick(); expect_out("single.t1", 1'b1, 3'd0, 2'b00);
    tick(); expect_out("single.t2", 1'b1, 3'd0, 2'b00);
    tick(); expect_out("single.t3", 1'b1, 3'd0, 2'b00);
    bus_if.cpu_ack = 1'b1;
    tick(); expect_out("single.ack", 1'b0, 3'd0, 2'b01);
    bus_if.cpu_ack = 1'b0;
    bus_if.raise   = 2'b00;
    tick(); expect_out("single.hold", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("single.idle", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("single.quiet", 1'b0, 3'd0, 2'b00);

    // Priority
    bus_if.raise = 2'b11;
    tick(); expect_out("prio.first", 1'b1, 3'd0, 2'b00);
    bus_if.cpu_ack = 1'b1;
    tick(); expect_out("prio.ack0", 1'b0, 3'd0, 2'b01);
    bus_if.cpu_ack = 1'b0;
    bus_if.raise   = 2'b10;
    tick(); expect_out("prio.hold", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("prio.idle", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("prio.second", 1'b1, 3'd1, 2'b00);
    bus_if.cpu_ack = 1'b1;
    tick(); expect_out("prio.ack1", 1'b0, 3'd0, 2'b10);
    bus_if.cpu_ack = 1'b0;
    bus_if.raise   = 2'b00;
    tick(); expect_out("prio.hold2", 1'b0, 3'd0, 2'b00);
    tick();
    tick(); expect_out("prio.done", 1'b0, 3'd0, 2'b00);

    // Mask
    bus_write(MASK_A, 8'h01);
    bus_if.raise = 2'b10;
    repeat (3) begin
      tick(); expect_out("mask.blocked", 1'b0, 3'd0, 2'b00);
    end
    bus_read(MASK_A, d);
    chk("mask.rd_mask", 32'(d), 32'h01);
    bus_read(PEND_A, d);
    chk("mask.rd_pend", 32'(d), 32'h02);
    check_release("mask.bus_released");
    bus_write(MASK_A, 8'h03);
    expect_out("mask.unmask_idle", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("mask.unmask_req", 1'b1, 3'd1, 2'b00);

    // No preemption, request persists through mask change and dropped raise
    bus_if.raise = 2'b11;
    bus_write(MASK_A, 8'h02);
    expect_out("np.id_stays", 1'b1, 3'd1, 2'b00);
    bus_if.raise = 2'b01;
    tick(); expect_out("np.persist", 1'b1, 3'd1, 2'b00);
    bus_if.cpu_ack = 1'b1;
    tick(); expect_out("np.ack1", 1'b0, 3'd0, 2'b10);
    bus_if.cpu_ack = 1'b0;
    tick(); expect_out("np.hold", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("np.idle", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("np.masked_a", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("np.masked_b", 1'b0, 3'd0, 2'b00);
    bus_write(MASK_A, 8'h03);
    expect_out("np.reen_idle", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("np.reen_req", 1'b1, 3'd0, 2'b00);
    bus_if.cpu_ack = 1'b1;
    tick(); expect_out("np.ack0", 1'b0, 3'd0, 2'b01);
    bus_if.cpu_ack = 1'b0;
    bus_if.raise   = 2'b00;
    tick();
    tick();

    // Re-raise during HOLD, CPU ack held high outside REQ
    bus_if.raise = 2'b01;
    tick(); expect_out("rr.req", 1'b1, 3'd0, 2'b00);
    bus_if.cpu_ack = 1'b1;
    tick(); expect_out("rr.ack", 1'b0, 3'd0, 2'b01);
    bus_if.raise = 2'b00;
    tick(); expect_out("rr.hold", 1'b0, 3'd0, 2'b00);
    bus_if.raise = 2'b01;
    tick(); expect_out("rr.idle", 1'b0, 3'd0, 2'b00);
    tick(); expect_out("rr.new_req", 1'b1, 3'd0, 2'b00);
    bus_if.cpu_ack = 1'b0;
    tick(); expect_out("rr.req_hold", 1'b1, 3'd0, 2'b00);
    bus_if.cpu_ack = 1'b1;
    tick(); expect_out("rr.ack2", 1'b0, 3'd0, 2'b01);
    bus_if.cpu_ack = 1'b0;
    bus_if.raise   = 2'b00;
    tick();
    tick();

    // Asynchronous reset mid-request while the bus is being driven
    bus_write(MASK_A, 8'h01);
    bus_if.raise = 2'b01;
    tick(); expect_out("rst.pre_req", 1'b1, 3'd0, 2'b00);
    bus_if.bus_addr = MASK_A;
    tick();
    bus_if.bus_addr = IDLE_A;
    #1 rst_n = 1'b0;
    check_release("rst.bus_released");
    expect_out("rst.async", 1'b0, 3'd0, 2'b00);
    chk("rst.id", 32'(bus_if.cpu_id), 32'd0);
    bus_if.cpu_ack = 1'b1;
    tick(); expect_out("rst.no_ack", 1'b0, 3'd0, 2'b00);
    bus_if.cpu_ack = 1'b0;
    bus_if.raise   = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(MASK_A, d);
    chk("rst.mask", 32'(d), 32'h03);

    // Randomized: service order is ascending index over raise & mask
    for (int it = 0; it < 40; it++) begin
      m = int'($urandom_range(0, 3));
      r = int'($urandom_range(1, 3));
      bus_write(MASK_A, {6'($urandom), 2'(m)});
      bus_read(MASK_A, d);
      chk("rnd.mask_rd", 32'(d), 32'(m));
      bus_if.raise    = 2'(r);
      bus_if.bus_addr = PEND_A;
      tick();
      chk("rnd.pend_rd", 32'(bus_data), 32'(r));
      bus_if.bus_addr = IDLE_A;
      e = r & m;
      while (e != 0) begin
        low = e & -e;
        id  = $clog2(low);
        expect_out("rnd.req", 1'b1, 3'(id), 2'b00);
        dly = int'($urandom_range(0, 2));
        repeat (dly) begin
          tick(); expect_out("rnd.req_wait", 1'b1, 3'(id), 2'b00);
        end
        bus_if.cpu_ack = 1'b1;
        tick(); expect_out("rnd.ack", 1'b0, 3'd0, 2'(low));
        bus_if.cpu_ack = 1'b0;
        bus_if.raise   = bus_if.raise & ~2'(low);
        e = e & ~low;
        tick(); expect_out("rnd.hold", 1'b0, 3'd0, 2'b00);
        tick(); expect_out("rnd.idle", 1'b0, 3'd0, 2'b00);
        tick();
      end
      expect_out("rnd.none", 1'b0, 3'd0, 2'b00);
      bus_if.raise = '0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
